// File: rtl/bmp_stream_writer_if.sv
// bmp_stream_writer_if: byte-stream handshake carrying the BMP file out of
// bmp_stream_writer.
//   o_byte  : current file byte (writer -> consumer)
//   o_valid : o_byte is valid (writer -> consumer)
//   i_ready : consumer takes the byte when o_valid && i_ready (consumer -> writer)
interface bmp_stream_writer_if;
  logic [7:0] o_byte;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_byte, output o_valid, input i_ready);
  modport slave  (input o_byte, input o_valid, output i_ready);
endinterface

// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: captures one WIDTH x HEIGHT RGB888 frame (qualified by
// HSYNC) into a frame buffer, then streams it out as a complete 24-bit BMP
// file: 54-byte header, then rows bottom-up as B,G,R triplets padded to 4 bytes.
//   HCLK, HRESETn        : clock, async active-low reset
//   HSYNC, DATA_R/G/B    : pixel input, one pixel per HSYNC-high cycle
//   bs (master)          : o_byte / o_valid / i_ready byte stream
//   o_busy               : not IDLE
//   o_done               : one-cycle pulse after the last file byte is taken
//   o_overrun            : sticky, HSYNC seen while the frame is being emitted
module bmp_stream_writer #(
  parameter int WIDTH  = 300,
  parameter int HEIGHT = 400
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSYNC,
  input  logic [7:0]          DATA_R,
  input  logic [7:0]          DATA_G,
  input  logic [7:0]          DATA_B,
  bmp_stream_writer_if.master bs,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overrun
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int ROWB = ((3 * WIDTH + 3) / 4) * 4;
  localparam int PAD  = ROWB - 3 * WIDTH;
  localparam logic [31:0] IMG = 32'(ROWB * HEIGHT);
  localparam logic [31:0] FSZ = 32'(54 + ROWB * HEIGHT);

  typedef enum logic [2:0] {IDLE, CAPTURE, HEADER, PIXELS, DONE} state_t;

  // Header byte i: pick the field covering i, then the little-endian byte of it.
  function automatic logic [7:0] hdr_byte(input logic [5:0] i);
    logic [31:0] f;
    logic [5:0]  b;
    logic [1:0]  sh;
    f = '0;
    b = '0;
    if      (i >= 6'd2  && i <= 6'd5 ) begin f = FSZ;            b = 6'd2;  end
    else if (i >= 6'd10 && i <= 6'd13) begin f = 32'd54;         b = 6'd10; end
    else if (i >= 6'd14 && i <= 6'd17) begin f = 32'd40;         b = 6'd14; end
    else if (i >= 6'd18 && i <= 6'd21) begin f = 32'(WIDTH);     b = 6'd18; end
    else if (i >= 6'd22 && i <= 6'd25) begin f = 32'(HEIGHT);    b = 6'd22; end
    else if (i >= 6'd26 && i <= 6'd27) begin f = 32'd1;          b = 6'd26; end
    else if (i >= 6'd28 && i <= 6'd29) begin f = 32'd24;         b = 6'd28; end
    else if (i >= 6'd34 && i <= 6'd37) begin f = IMG;            b = 6'd34; end
    sh = 2'(i - b);
    hdr_byte = f[{sh, 3'b000} +: 8];
    if (i == 6'd0) hdr_byte = 8'h42;
    if (i == 6'd1) hdr_byte = 8'h4D;
  endfunction

  state_t        st_q;
  logic [AW-1:0] wr_q;
  logic [5:0]    hcnt_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [1:0]    comp_q, pad_q;
  logic          padding_q, fetch_q, last_q;
  logic [7:0]    byte_q;
  logic          valid_q, busy_q, done_q, ovr_q;
  logic [23:0]   rd_q;
  logic [23:0]   mem_q [NPIX];

  logic          can_load, wr_en, row_end;
  logic [AW-1:0] wr_idx, rd_addr;
  logic [7:0]    pix_byte;

  assign can_load = !valid_q || bs.i_ready;
  assign wr_en    = HSYNC && (st_q == IDLE || st_q == CAPTURE);
  assign wr_idx   = (st_q == IDLE) ? '0 : wr_q;
  assign rd_addr  = AW'(int'(row_q) * WIDTH + int'(col_q));

  always_comb begin
    pix_byte = rd_q[23:16];
    case (comp_q)
      2'd0:    pix_byte = rd_q[7:0];
      2'd1:    pix_byte = rd_q[15:8];
      default: pix_byte = rd_q[23:16];
    endcase
  end

  // The byte being loaded now is the last one of its row (padding or, with
  // no padding, the R of the last column).
  always_comb begin
    row_end = 1'b0;
    if (padding_q) row_end = (pad_q == 2'(PAD - 1));
    else           row_end = (comp_q == 2'd2) && (col_q == CW'(WIDTH - 1)) && (PAD == 0);
  end

  // Frame buffer: one write port, registered read port.
  always_ff @(posedge HCLK) begin
    if (wr_en) mem_q[wr_idx] <= {DATA_R, DATA_G, DATA_B};
    rd_q <= mem_q[rd_addr];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st_q      <= IDLE;
      wr_q      <= '0;
      hcnt_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      comp_q    <= '0;
      pad_q     <= '0;
      padding_q <= 1'b0;
      fetch_q   <= 1'b0;
      last_q    <= 1'b0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      // fetch_q marks rd_q as stale for exactly the cycle after an address move.
      fetch_q <= 1'b0;
      if (HSYNC && (st_q == HEADER || st_q == PIXELS || st_q == DONE)) ovr_q <= 1'b1;
      case (st_q)
        IDLE: if (HSYNC) begin
          wr_q   <= AW'(1);
          busy_q <= 1'b1;
          hcnt_q <= '0;
          st_q   <= (NPIX == 1) ? HEADER : CAPTURE;
        end
        CAPTURE: if (HSYNC) begin
          wr_q <= wr_q + 1'b1;
          if (wr_q == AW'(NPIX - 1)) begin
            hcnt_q <= '0;
            st_q   <= HEADER;
          end
        end
        HEADER: if (can_load) begin
          byte_q  <= hdr_byte(hcnt_q);
          valid_q <= 1'b1;
          hcnt_q  <= hcnt_q + 6'd1;
          if (hcnt_q == 6'd53) begin
            row_q     <= RW'(HEIGHT - 1);
            col_q     <= '0;
            comp_q    <= '0;
            pad_q     <= '0;
            padding_q <= 1'b0;
            last_q    <= 1'b0;
            fetch_q   <= 1'b1;
            st_q      <= PIXELS;
          end
        end
        PIXELS: begin
          if (last_q) begin
            // Final byte is in o_byte; leave once it is taken.
            if (bs.i_ready) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              st_q    <= DONE;
            end
          end else if (can_load) begin
            if (padding_q || !fetch_q) begin
              byte_q  <= padding_q ? 8'h00 : pix_byte;
              valid_q <= 1'b1;
              if (row_end) begin
                padding_q <= 1'b0;
                pad_q     <= '0;
                comp_q    <= '0;
                col_q     <= '0;
                if (row_q == '0) last_q <= 1'b1;
                else begin
                  row_q   <= row_q - 1'b1;
                  fetch_q <= 1'b1;
                end
              end else if (padding_q) begin
                pad_q <= pad_q + 2'd1;
              end else if (comp_q == 2'd2) begin
                comp_q <= '0;
                if (col_q == CW'(WIDTH - 1)) padding_q <= 1'b1;
                else begin
                  col_q   <= col_q + 1'b1;
                  fetch_q <= 1'b1;
                end
              end else begin
                comp_q <= comp_q + 2'd1;
              end
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          st_q   <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign bs.o_byte  = byte_q;
  assign bs.o_valid = valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_overrun  = ovr_q;
endmodule

// File: tb/tb_bmp_stream_writer.sv
// Bench for bmp_stream_writer: a 3x2 instance (padded rows) and a 4x1
// instance (no padding). Expected BMP bytes are built from the driven pixels
// into per-instance queues and popped as the DUT hands bytes over.
module tb_bmp_stream_writer;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic hs_a = 1'b0, hs_b = 1'b0;
  logic [7:0] dr = '0, dg = '0, db = '0;
  logic busy_a, done_a_o, ovr_a, busy_b, done_b_o, ovr_b;

  bmp_stream_writer_if ifa();
  bmp_stream_writer_if ifb();

  bmp_stream_writer #(.WIDTH(3), .HEIGHT(2)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(hs_a),
    .DATA_R(dr), .DATA_G(dg), .DATA_B(db), .bs(ifa),
    .o_busy(busy_a), .o_done(done_a_o), .o_overrun(ovr_a));

  bmp_stream_writer #(.WIDTH(4), .HEIGHT(1)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(hs_b),
    .DATA_R(dr), .DATA_G(dg), .DATA_B(db), .bs(ifb),
    .o_busy(busy_b), .o_done(done_b_o), .o_overrun(ovr_b));

  always #5 HCLK = ~HCLK;

  int n_checks = 0, n_fail = 0;
  int done_a = 0, done_b = 0;
  logic [7:0] qa[$], qb[$], got_a[$], got_b[$], mq[$], ref_q[$];
  logic [7:0] exp_a, exp_b, hold_a;
  logic stall_a = 1'b0;

  // ---------------- output monitors / scoreboard ----------------
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (stall_a) begin
        n_checks++;
        if (ifa.o_valid !== 1'b1 || ifa.o_byte !== hold_a) begin
          n_fail++;
          $display("FAIL hold_stable_a: got valid=%b byte=%02h, need valid=1 byte=%02h",
                   ifa.o_valid, ifa.o_byte, hold_a);
        end
      end
      stall_a = ifa.o_valid && !ifa.i_ready;
      hold_a  = ifa.o_byte;
      if (ifa.o_valid && ifa.i_ready) begin
        got_a.push_back(ifa.o_byte);
        n_checks++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL stream_a: got extra byte %02h at %0d, need none", ifa.o_byte, got_a.size() - 1);
        end else begin
          exp_a = qa.pop_front();
          if (ifa.o_byte !== exp_a) begin
            n_fail++;
            $display("FAIL stream_a[%0d]: got %02h, need %02h", got_a.size() - 1, ifa.o_byte, exp_a);
          end
        end
      end
      if (done_a_o) done_a++;
    end else begin
      stall_a = 1'b0;
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (ifb.o_valid && ifb.i_ready) begin
        got_b.push_back(ifb.o_byte);
        n_checks++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL stream_b: got extra byte %02h, need none", ifb.o_byte);
        end else begin
          exp_b = qb.pop_front();
          if (ifb.o_byte !== exp_b) begin
            n_fail++;
            $display("FAIL stream_b[%0d]: got %02h, need %02h", got_b.size() - 1, ifb.o_byte, exp_b);
          end
        end
      end
      if (done_b_o) done_b++;
    end
  end

  // ---------------- reference BMP model ----------------
  task automatic put32(input int v);
    for (int k = 0; k < 4; k++) mq.push_back(8'(v >> (8 * k)));
  endtask

  task automatic put16(input int v);
    for (int k = 0; k < 2; k++) mq.push_back(8'(v >> (8 * k)));
  endtask

  // Pixel i of every frame: R=i, G=0x10+i, B=0x20+i.
  task automatic model_bmp(input int w, input int h);
    int rowb, img;
    mq.delete();
    rowb = ((3 * w + 3) / 4) * 4;
    img  = rowb * h;
    mq.push_back(8'h42);
    mq.push_back(8'h4D);
    put32(54 + img); put32(0); put32(54); put32(40); put32(w); put32(h);
    put16(1); put16(24); put32(0); put32(img);
    repeat (4) put32(0);
    for (int r = h - 1; r >= 0; r--) begin
      for (int c = 0; c < w; c++) begin
        automatic int i = r * w + c;
        mq.push_back(8'(8'h20 + i));
        mq.push_back(8'(8'h10 + i));
        mq.push_back(8'(i));
      end
      for (int p = 3 * w; p < rowb; p++) mq.push_back(8'h00);
    end
  endtask

  // Drive one 3x2 frame into dut_a and drain it. pat gives HSYNC for the
  // first 8 capture cycles; ovr_at>0 pulses HSYNC once after that many
  // bytes; stop_at>0 returns early once that many bytes are taken.
  task automatic run_frame_a(input logic [7:0] pat, input bit rnd, input int ovr_at,
                             input int stop_at, output bit ok, output int cyc);
    int idx, c, d0;
    bit fired;
    idx = 0; c = 0; fired = 0; ok = 0; cyc = 0;
    model_bmp(3, 2);
    foreach (mq[i]) qa.push_back(mq[i]);
    d0 = done_a;
    ifa.i_ready = 1'b1;
    while (idx < 6) begin
      @(posedge HCLK); #1;
      hs_a = (c < 8) ? pat[c] : 1'b1;
      if (hs_a) begin
        dr = 8'(idx); dg = 8'(8'h10 + idx); db = 8'(8'h20 + idx);
        idx++;
      end else begin
        dr = 8'hAA; dg = 8'hAA; db = 8'hAA;
      end
      c++;
    end
    @(posedge HCLK); #1;
    hs_a = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      ifa.i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ovr_at > 0 && !fired && got_a.size() >= ovr_at) begin
        hs_a = 1'b1; dr = 8'hEE; dg = 8'hEE; db = 8'hEE; fired = 1;
      end else begin
        hs_a = 1'b0;
      end
      @(posedge HCLK); #1;
      if (done_a != d0 || (stop_at > 0 && got_a.size() >= stop_at)) begin
        ok = 1; cyc = k; break;
      end
    end
    hs_a = 1'b0;
    ifa.i_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_checks++;
    if (ifa.o_byte !== 8'h00 || ifa.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_a: got byte=%02h valid=%b, need 00/0", ifa.o_byte, ifa.o_valid);
    end
    n_checks++;
    if ({busy_a, done_a_o, ovr_a} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags_a: got busy/done/ovr=%b%b%b, need 000", busy_a, done_a_o, ovr_a);
    end
    n_checks++;
    if ({ifb.o_valid, busy_b, done_b_o, ovr_b} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_b: got valid/busy/done/ovr=%b%b%b%b, need 0000",
                         ifb.o_valid, busy_b, done_b_o, ovr_b);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_basic();
    bit ok; int cyc, d0;
    logic [7:0] ref_data [24] = '{8'h23, 8'h13, 8'h03, 8'h24, 8'h14, 8'h04, 8'h25, 8'h15,
                                   8'h05, 8'h00, 8'h00, 8'h00, 8'h20, 8'h10, 8'h00, 8'h21,
                                   8'h11, 8'h01, 8'h22, 8'h12, 8'h02, 8'h00, 8'h00, 8'h00};
    got_a.delete();
    d0 = done_a;
    run_frame_a(8'hFF, 0, 0, 0, ok, cyc);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no o_done, need o_done"); end
    n_checks++;
    if (got_a.size() != 78) begin n_fail++; $display("FAIL basic_len: got %0d, need 78", got_a.size()); end
    if (got_a.size() >= 78) begin
      n_checks++;
      if ({got_a[5], got_a[4], got_a[3], got_a[2]} !== 32'h4E) begin
        n_fail++; $display("FAIL basic_fsz: got %02h %02h %02h %02h, need 4E 00 00 00",
                           got_a[2], got_a[3], got_a[4], got_a[5]);
      end
      n_checks++;
      if ({got_a[37], got_a[36], got_a[35], got_a[34]} !== 32'h18) begin
        n_fail++; $display("FAIL basic_img: got %02h %02h %02h %02h, need 18 00 00 00",
                           got_a[34], got_a[35], got_a[36], got_a[37]);
      end
      for (int i = 0; i < 24; i++) begin
        n_checks++;
        if (got_a[54 + i] !== ref_data[i]) begin
          n_fail++; $display("FAIL basic_data[%0d]: got %02h, need %02h", i, got_a[54 + i], ref_data[i]);
        end
      end
    end
    n_checks++;
    if (cyc > 3 * 78 + 10) begin n_fail++; $display("FAIL basic_rate: got %0d cycles, need <= %0d", cyc, 3 * 78 + 10); end
    repeat (5) @(posedge HCLK);
    #1;
    n_checks++;
    if (done_a - d0 != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d, need 1", done_a - d0); end
    n_checks++;
    if (busy_a !== 1'b0 || ovr_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: got busy=%b ovr=%b, need 0/0", busy_a, ovr_a);
    end
    n_checks++;
    if (qa.size() != 0) begin n_fail++; $display("FAIL basic_left: got %0d bytes unsent, need 0", qa.size()); end
    ref_q = got_a;
  endtask

  task automatic test_nopad();
    bit ok; int d0;
    ok = 0;
    got_b.delete();
    model_bmp(4, 1);
    foreach (mq[i]) qb.push_back(mq[i]);
    d0 = done_b;
    ifb.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge HCLK); #1;
      hs_b = 1'b1; dr = 8'(i); dg = 8'(8'h10 + i); db = 8'(8'h20 + i);
    end
    @(posedge HCLK); #1;
    hs_b = 1'b0;
    n_checks++;
    if (busy_b !== 1'b1) begin n_fail++; $display("FAIL nopad_busy: got %b, need 1", busy_b); end
    for (int k = 0; k < 1000; k++) begin
      @(posedge HCLK); #1;
      if (done_b != d0) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL nopad_timeout: got no o_done, need o_done"); end
    n_checks++;
    if (got_b.size() != 66) begin n_fail++; $display("FAIL nopad_len: got %0d, need 66", got_b.size()); end
    if (got_b.size() == 66) begin
      n_checks++;
      if (got_b[65] !== 8'h03) begin n_fail++; $display("FAIL nopad_last: got %02h, need 03", got_b[65]); end
    end
    n_checks++;
    if (qb.size() != 0) begin n_fail++; $display("FAIL nopad_left: got %0d, need 0", qb.size()); end
  endtask

  task automatic test_gapped();
    bit ok; int cyc, mism;
    got_a.delete();
    run_frame_a(8'hCD, 0, 0, 0, ok, cyc);
    mism = 0;
    foreach (ref_q[i]) if (i >= got_a.size() || got_a[i] !== ref_q[i]) mism++;
    n_checks++;
    if (!ok || got_a.size() != ref_q.size() || mism != 0) begin
      n_fail++; $display("FAIL gapped_stream: got len=%0d mism=%0d ok=%0d, need len=%0d mism=0 ok=1",
                         got_a.size(), mism, ok, ref_q.size());
    end
    n_checks++;
    if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL gapped_ovr: got %b, need 0", ovr_a); end
  endtask

  task automatic test_random_ready();
    bit ok; int cyc, mism;
    got_a.delete();
    run_frame_a(8'hFF, 1, 0, 0, ok, cyc);
    mism = 0;
    foreach (ref_q[i]) if (i >= got_a.size() || got_a[i] !== ref_q[i]) mism++;
    n_checks++;
    if (!ok || got_a.size() != ref_q.size() || mism != 0) begin
      n_fail++; $display("FAIL rand_ready_stream: got len=%0d mism=%0d ok=%0d, need len=%0d mism=0 ok=1",
                         got_a.size(), mism, ok, ref_q.size());
    end
  endtask

  task automatic test_overrun();
    bit ok; int cyc, mism;
    got_a.delete();
    run_frame_a(8'hFF, 0, 60, 0, ok, cyc);
    mism = 0;
    foreach (ref_q[i]) if (i >= got_a.size() || got_a[i] !== ref_q[i]) mism++;
    n_checks++;
    if (!ok || got_a.size() != ref_q.size() || mism != 0) begin
      n_fail++; $display("FAIL overrun_stream: got len=%0d mism=%0d, need len=%0d mism=0",
                         got_a.size(), mism, ref_q.size());
    end
    n_checks++;
    if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, need 1", ovr_a); end
    repeat (4) @(posedge HCLK);
    #1;
    n_checks++;
    if (ovr_a !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b, need 1", ovr_a); end
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc, mism;
    got_a.delete();
    run_frame_a(8'hFF, 0, 0, 20, ok, cyc);
    n_checks++;
    if (!ok || ifa.o_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_reach: got ok=%0d valid=%b, need 1/1", ok, ifa.o_valid);
    end
    HRESETn = 1'b0;
    #1;
    n_checks++;
    if (ifa.o_valid !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL midreset_abort: got valid=%b busy=%b, need 0/0", ifa.o_valid, busy_a);
    end
    n_checks++;
    if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL midreset_ovr: got %b, need 0", ovr_a); end
    qa.delete();
    got_a.delete();
    @(negedge HCLK);
    HRESETn = 1'b1;
    run_frame_a(8'hFF, 0, 0, 0, ok, cyc);
    mism = 0;
    foreach (ref_q[i]) if (i >= got_a.size() || got_a[i] !== ref_q[i]) mism++;
    n_checks++;
    if (!ok || got_a.size() != 78 || mism != 0) begin
      n_fail++; $display("FAIL midreset_refill: got len=%0d mism=%0d ok=%0d, need len=78 mism=0 ok=1",
                         got_a.size(), mism, ok);
    end
    n_checks++;
    if (qa.size() != 0) begin n_fail++; $display("FAIL midreset_left: got %0d, need 0", qa.size()); end
  endtask

  initial begin
    ifa.i_ready = 1'b1;
    ifb.i_ready = 1'b1;
    test_reset();
    test_basic();
    test_nopad();
    test_gapped();
    test_random_ready();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
